// File: rtl/prio_encoder_arb.sv
// Registered N-line priority encoder / arbiter: sticky pending capture, fixed or
// round-robin selection, and a valid/ready index port with back-to-back grants.
module prio_encoder_arb #(
  parameter int N          = 10,
  parameter int W          = $clog2(N),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         en,
  input  logic         mode,
  output logic [N-1:0] pending,
  output logic         gs,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state;
  logic [W-1:0] rr_ptr;
  logic [N-1:0] act;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [W-1:0] sel;
  logic [W-1:0] sel_hi;
  logic [W-1:0] sel_lo;
  logic         found_hi;
  logic         found_lo;
  logic         grant;
  int           thr;

  assign act  = ACTIVE_LOW ? ~req : req;
  assign elig = pending & ~mask;
  assign gs   = |elig;

  // Round-robin is two ordered scans: indices above rr_ptr first, then the rest
  // (rr_ptr last). Fixed priority is the same scan with the threshold below 0.
  always_comb begin
    thr      = mode ? int'(rr_ptr) : -1;
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (i > thr) && !found_hi) begin
        sel_hi   = W'(i);
        found_hi = 1'b1;
      end
      if (elig[i] && (i <= thr) && !found_lo) begin
        sel_lo   = W'(i);
        found_lo = 1'b1;
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  assign grant = en && gs && ((state == IDLE) || out_ready);
  assign clr   = grant ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      rr_ptr    <= W'(N - 1);
    end else begin
      // set after clear so a level-held request re-pends immediately
      pending <= (pending & ~clr) | act;
      case (state)
        IDLE: begin
          if (grant) begin
            out_idx   <= sel;
            out_valid <= 1'b1;
            rr_ptr    <= sel;
            state     <= HOLD;
          end else begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (grant) begin
              out_idx   <= sel;
              out_valid <= 1'b1;
              rr_ptr    <= sel;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Bench for prio_encoder_arb: directed vector table, hand-written corner
// sequences, and random traffic checked against a behavioural model.
module tb_prio_encoder_arb;
  localparam int N = 10;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         en;
  logic         mode;
  logic [N-1:0] pending;
  logic         gs;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;

  int total = 0;
  int bad   = 0;

  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_idx;
  int         m_ptr;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         rdy;
    logic         exp_valid;
    int           exp_idx;
    logic [N-1:0] exp_pend;
    logic         exp_gs;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  prio_encoder_arb #(.N(N), .W(W), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .en(en), .mode(mode),
    .pending(pending), .gs(gs), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Search order written out directly: lowest index, or starting just past the pointer.
  function automatic int pick(bit [N-1:0] e, bit md, int ptr);
    int start;
    start = md ? ptr + 1 : 0;
    for (int k = 0; k < N; k++) begin
      if (e[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = N - 1;
  endtask

  task automatic model_edge();
    bit [N-1:0] e;
    int s;
    bit g;
    e = m_pend & ~mask;
    s = pick(e, mode, m_ptr);
    g = 1'b0;
    if (!m_valid || out_ready) begin
      if (en && (e != 0)) g = 1'b1;
      else m_valid = 1'b0;
    end
    if (g) begin
      m_pend[s] = 1'b0;
      m_valid   = 1'b1;
      m_idx     = s;
      m_ptr     = s;
    end
    m_pend = m_pend | ~req;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    check("model_pending", 32'(pending), 32'(m_pend));
    check("model_valid", 32'(out_valid), 32'(m_valid));
    check("model_gs", 32'(gs), 32'(|(m_pend & ~mask)));
    if (m_valid) check("model_idx", 32'(out_idx), 32'(m_idx));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '1; mask = '0; en = 1'b1; mode = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle inputs after reset: nothing pends, nothing granted
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_pending", 32'(pending), 32'h0);
      check("idle_gs", 32'(gs), 32'h0);
      check("idle_valid", 32'(out_valid), 32'h0);
    end

    // fixed-priority pulse of lines 3,5 then masked line 6
    tbl[0] = '{10'h3D7, 10'h000, 1'b1, 1'b0, -1, 10'h028, 1'b1};
    tbl[1] = '{10'h3FF, 10'h000, 1'b1, 1'b1,  3, 10'h020, 1'b1};
    tbl[2] = '{10'h3FF, 10'h000, 1'b1, 1'b1,  5, 10'h000, 1'b0};
    tbl[3] = '{10'h3FF, 10'h000, 1'b1, 1'b0, -1, 10'h000, 1'b0};
    tbl[4] = '{10'h3BF, 10'h040, 1'b1, 1'b0, -1, 10'h040, 1'b0};
    tbl[5] = '{10'h3FF, 10'h040, 1'b1, 1'b0, -1, 10'h040, 1'b0};
    tbl[6] = '{10'h3FF, 10'h000, 1'b1, 1'b1,  6, 10'h000, 1'b0};
    tbl[7] = '{10'h3FF, 10'h000, 1'b1, 1'b0, -1, 10'h000, 1'b0};
    mode = 1'b0; en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      req = tbl[v].req; mask = tbl[v].mask; out_ready = tbl[v].rdy;
      step();
      check($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'(tbl[v].exp_valid));
      check($sformatf("tbl%0d_pending", v), 32'(pending), 32'(tbl[v].exp_pend));
      check($sformatf("tbl%0d_gs", v), 32'(gs), 32'(tbl[v].exp_gs));
      if (tbl[v].exp_idx >= 0)
        check($sformatf("tbl%0d_idx", v), 32'(out_idx), 32'(tbl[v].exp_idx));
    end

    // round-robin over held lines 2,7,9
    do_reset();
    mode = 1'b1; en = 1'b1; out_ready = 1'b1; mask = '0;
    req = ~10'h284;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_valid", 32'(out_valid), 32'h1);
      check($sformatf("rr_idx%0d", k), 32'(out_idx), (k % 3 == 0) ? 32'd2 : (k % 3 == 1) ? 32'd7 : 32'd9);
    end

    // grant held while not ready; en=0 blocks the follow-up grant
    do_reset();
    mode = 1'b0; en = 1'b1; out_ready = 1'b0;
    req = ~10'h010;
    step();
    req = '1;
    step();
    check("hold_valid", 32'(out_valid), 32'h1);
    check("hold_idx", 32'(out_idx), 32'd4);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_idx_stall", 32'(out_idx), 32'd4);
    end
    req = ~10'h001; en = 1'b0;
    step();
    check("hold_idx_en0", 32'(out_idx), 32'd4);
    req = '1;
    step();
    check("hold_pend0", 32'(pending[0]), 32'h1);
    out_ready = 1'b1;
    step();
    check("accept_en0_valid", 32'(out_valid), 32'h0);
    step();
    check("en0_no_grant", 32'(out_valid), 32'h0);
    en = 1'b1;
    step();
    check("en1_valid", 32'(out_valid), 32'h1);
    check("en1_idx", 32'(out_idx), 32'd0);

    // async reset during HOLD on line 8, then RR restarts from line 0
    do_reset();
    mode = 1'b1; en = 1'b1; out_ready = 1'b0;
    req = ~10'h100;
    step();
    req = '1;
    step();
    check("pre_rst_idx", 32'(out_idx), 32'd8);
    req = ~10'h008;
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_pending", 32'(pending), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = ~10'h220;
    step();
    req = '1;
    step();
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_idx", 32'(out_idx), 32'd5);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        req[b]  = ($urandom_range(3) != 0);
        mask[b] = ($urandom_range(7) == 0);
      end
      en        = ($urandom_range(7) != 0);
      out_ready = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) mode = ~mode;
      step();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
